mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified memory port between the instruction cache (line fills, read-only)
//  and the data cache (line fills and dirty-line write-backs). Latches the winning request,
//  drives the memory handshake until mem_rdy or timeout, and returns a one-cycle done pulse
//  with registered data to the winner. Sits between the two cache controllers and unified_mem.
// PARAMETERS
//  ADDR_W      14   line address width (PC[15:2]-style line index)
//  DATA_W      64   cache line / memory data width
//  STARVE_MAX  4    consecutive dcache grants with icache waiting before icache is forced in
//  TIMEOUT     255  cycles to wait for mem_rdy before aborting with error
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst_n       in   1        asynchronous reset, active low
//  ic_req      in   1        icache fill request; held until ic_done
//  ic_addr     in   ADDR_W   icache line address; stable while ic_req
//  ic_done     out  1        one-cycle pulse: ic_rdata valid / request finished
//  ic_rdata    out  DATA_W   fill data for icache
//  dc_req      in   1        dcache request; held until dc_done
//  dc_we       in   1        1 = write-back, 0 = fill; stable while dc_req
//  dc_addr     in   ADDR_W   dcache line address; stable while dc_req
//  dc_wdata    in   DATA_W   write-back data; stable while dc_req
//  dc_done     out  1        one-cycle pulse: dc_rdata valid (read) / write committed
//  dc_rdata    out  DATA_W   fill data for dcache
//  mem_re      out  1        unified memory read strobe, level, held until mem_rdy
//  mem_we      out  1        unified memory write strobe, level, held until mem_rdy
//  mem_addr    out  ADDR_W   unified memory line address
//  mem_wdata   out  DATA_W   unified memory write data
//  mem_rdata   in   DATA_W   unified memory read data, valid when mem_rdy
//  mem_rdy     in   1        memory completion, one cycle
//  busy        out  1        state != IDLE (feeds pipeline stall logic)
//  err         out  1        sticky: set on any timeout, cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; starve_cnt=0; timer=0; err=0.
//   Reset mid-transaction aborts immediately; mem_re/mem_we drop in the same cycle.
//  States: IDLE, IC_RD, DC_RD, DC_WR, RESP.
//  IDLE: evaluate requests each cycle; on grant, register mem_addr (and mem_wdata for DC_WR)
//   and owner; next state IC_RD / DC_RD / DC_WR.
//  Arbitration (IDLE only): dc_req alone -> dcache; ic_req alone -> icache; both -> dcache
//   unless starve_cnt==STARVE_MAX, then icache. starve_cnt: +1 (saturating) on a dcache
//   grant while ic_req=1; cleared on icache grant or on any grant with ic_req=0.
//  IC_RD/DC_RD: mem_re=1; DC_WR: mem_we=1; never both. timer +1 per cycle in state.
//   mem_rdy=1 -> capture mem_rdata into owner's rdata register (reads only), go RESP.
//   timer==TIMEOUT without mem_rdy -> set err, rdata unchanged, go RESP.
//  RESP (1 cycle): owner's done=1, other done=0, mem strobes 0, timer cleared; next IDLE.
//   Requester must deassert req in the cycle after done; IDLE re-evaluates then.
//  Latency: req seen in IDLE cycle 0 -> strobe cycles 1..N (N>=1, mem_rdy at N) -> done at N+1.
//   Minimum req-to-done 2 cycles; one idle cycle between back-to-back transactions.
//  rdata outputs hold last captured value until the next capture for that requester.
//  Requests that change or drop mid-transaction are ignored until RESP; no cancel support.
//  mem_rdy outside IC_RD/DC_RD/DC_WR is ignored.
//  Width: timer is clog2(TIMEOUT+1) bits; starve_cnt clog2(STARVE_MAX+1) bits, saturating.
// TESTING
//  1 ic_req=1 addr=0x0123, mem_rdy 3 cyc after mem_re, rdata=0xDEADBEEF_CAFEF00D -> mem_addr=0x0123,
//    mem_re high 3 cyc, ic_done 1 cyc later with ic_rdata=0xDEADBEEF_CAFEF00D, busy low next.
//  2 ic_req & dc_req (dc_we=1, addr=0x0040, wdata=0x1111_2222_3333_4444) same cycle -> dcache first
//    (mem_we, mem_wdata match), dc_done, then idle cycle, then icache read, ic_done.
//  3 dc_req held continuously with ic_req high -> 4 dcache grants, 5th grant goes to icache,
//    starve_cnt returns 0.
//  4 dc read, mem_rdy never asserted -> mem_re high 255 cyc, err=1, dc_done pulse, err stays 1.
//  5 rst_n low during DC_WR -> mem_we, busy, done drop immediately; after release state IDLE, err=0.
//  6 mem_rdy pulsed while IDLE -> no done, no data captured, outputs unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified memory port between icache fills and dcache fills/write-backs.
// Latches the winner, runs the memory handshake with a timeout, and pulses done to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              err
);

  localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  // Expiry fires in the strobe cycle that completes TIMEOUT cycles of waiting.
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [2:0] {StIdle, StIcRd, StDcRd, StDcWr, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = dcache owns the transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                err_q, err_d;
  logic                ic_win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    timer_d    = timer_q;
    starve_d   = starve_q;
    err_d      = err_q;
    ic_win     = 1'b0;

    case (state_q)
      StIdle: begin
        ic_win = ic_req && (!dc_req || (starve_q == StarveMax));
        if (ic_win) begin
          state_d  = StIcRd;
          owner_d  = 1'b0;
          addr_d   = ic_addr;
          starve_d = '0;
        end else if (dc_req) begin
          state_d = dc_we ? StDcWr : StDcRd;
          owner_d = 1'b1;
          addr_d  = dc_addr;
          if (dc_we) begin
            wdata_d = dc_wdata;
          end
          if (!ic_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
      end

      StIcRd, StDcRd, StDcWr: begin
        timer_d = timer_q + TimerW'(1);
        if (mem_rdy) begin
          if (state_q == StIcRd) ic_rdata_d = mem_rdata;
          if (state_q == StDcRd) dc_rdata_d = mem_rdata;
          state_d = StResp;
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        timer_d = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      timer_q    <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      timer_q    <= timer_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_re    = (state_q == StIcRd) || (state_q == StDcRd);
  assign mem_we    = (state_q == StDcWr);
  assign busy      = (state_q != StIdle);
  assign ic_done   = (state_q == StResp) && !owner_q;
  assign dc_done   = (state_q == StResp) && owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, arbitration, starvation, timeout,
// reset abort and stray mem_rdy.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [13:0] ic_addr;
  logic        ic_done;
  logic [63:0] ic_rdata;
  logic        dc_req;
  logic        dc_we;
  logic [13:0] dc_addr;
  logic [63:0] dc_wdata;
  logic        dc_done;
  logic [63:0] dc_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;
  logic        busy;
  logic        err;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [63:0] exp_ic;
  logic [63:0] exp_dc;
  int          cnt;

  mem_arbiter #(
    .ADDR_W    (14),
    .DATA_W    (64),
    .STARVE_MAX(4),
    .TIMEOUT   (255)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_done  (ic_done),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_done  (dc_done),
    .dc_rdata (dc_rdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rdy  (mem_rdy),
    .busy     (busy),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_rdy   = 1'b0;
    exp_ic    = '0;
    exp_dc    = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_re", 64'(mem_re), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_icdone", 64'(ic_done), 64'd0);
    check("rst_dcdone", 64'(dc_done), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_icrdata", ic_rdata, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: icache fill, mem_rdy in third strobe cycle
    ic_req  = 1'b1;
    ic_addr = 14'h0123;
    tick();
    check("t1_re_c1", 64'(mem_re), 64'd1);
    check("t1_we_c1", 64'(mem_we), 64'd0);
    check("t1_addr", 64'(mem_addr), 64'h0123);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_re_c2", 64'(mem_re), 64'd1);
    check("t1_done_early", 64'(ic_done), 64'd0);
    tick();
    check("t1_re_c3", 64'(mem_re), 64'd1);
    mem_rdy   = 1'b1;
    mem_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    mem_rdy = 1'b0;
    exp_ic  = 64'hDEADBEEF_CAFEF00D;
    check("t1_icdone", 64'(ic_done), 64'd1);
    check("t1_dcdone", 64'(dc_done), 64'd0);
    check("t1_re_resp", 64'(mem_re), 64'd0);
    check("t1_rdata", ic_rdata, exp_ic);
    ic_req = 1'b0;
    tick();
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_icdone_off", 64'(ic_done), 64'd0);

    // 2: simultaneous requests, dcache write-back wins first
    ic_req   = 1'b1;
    ic_addr  = 14'h0200;
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 14'h0040;
    dc_wdata = 64'h1111_2222_3333_4444;
    tick();
    check("t2_we", 64'(mem_we), 64'd1);
    check("t2_re", 64'(mem_re), 64'd0);
    check("t2_addr", 64'(mem_addr), 64'h0040);
    check("t2_wdata", mem_wdata, 64'h1111_2222_3333_4444);
    mem_rdy   = 1'b1;
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_rdy = 1'b0;
    check("t2_dcdone", 64'(dc_done), 64'd1);
    check("t2_icdone", 64'(ic_done), 64'd0);
    check("t2_dcrdata_keep", dc_rdata, exp_dc);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    tick();
    check("t2_idle_gap", 64'(busy), 64'd0);
    tick();
    check("t2_ic_re", 64'(mem_re), 64'd1);
    check("t2_ic_addr", 64'(mem_addr), 64'h0200);
    mem_rdy   = 1'b1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rdy = 1'b0;
    exp_ic  = 64'h0123_4567_89AB_CDEF;
    check("t2_icdone", 64'(ic_done), 64'd1);
    check("t2_icrdata", ic_rdata, exp_ic);
    ic_req = 1'b0;
    tick();

    // 3: starvation, dcache reads held with icache waiting
    ic_req  = 1'b1;
    ic_addr = 14'h0300;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 14'h0050;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t3_grant%0d_addr", g), 64'(mem_addr), (g < 4) ? 64'h0050 : 64'h0300);
      check($sformatf("t3_grant%0d_re", g), 64'(mem_re), 64'd1);
      mem_rdy   = 1'b1;
      mem_rdata = 64'(g + 100);
      tick();
      mem_rdy = 1'b0;
      if (g < 4) exp_dc = 64'(g + 100);
      else exp_ic = 64'(g + 100);
      check($sformatf("t3_grant%0d_dcdone", g), 64'(dc_done), (g < 4) ? 64'd1 : 64'd0);
      check($sformatf("t3_grant%0d_icdone", g), 64'(ic_done), (g < 4) ? 64'd0 : 64'd1);
      if (g == 4) begin
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
      tick();
    end
    check("t3_dcrdata", dc_rdata, exp_dc);
    check("t3_icrdata", ic_rdata, exp_ic);
    // Counter back at zero: contention goes to dcache again
    ic_req = 1'b1;
    dc_req = 1'b1;
    tick();
    check("t3_after_addr", 64'(mem_addr), 64'h0050);
    mem_rdy   = 1'b1;
    mem_rdata = 64'h5555_6666_7777_8888;
    tick();
    mem_rdy = 1'b0;
    exp_dc  = 64'h5555_6666_7777_8888;
    check("t3_after_dcdone", 64'(dc_done), 64'd1);
    dc_req = 1'b0;
    tick();
    tick();
    check("t3_ic_follow", 64'(mem_addr), 64'h0300);
    mem_rdy   = 1'b1;
    mem_rdata = 64'h9999_AAAA_BBBB_CCCC;
    tick();
    mem_rdy = 1'b0;
    exp_ic  = 64'h9999_AAAA_BBBB_CCCC;
    check("t3_ic_follow_done", 64'(ic_done), 64'd1);
    ic_req = 1'b0;
    tick();

    // 6: stray mem_rdy while idle
    mem_rdy   = 1'b1;
    mem_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    mem_rdy = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_icdone", 64'(ic_done), 64'd0);
    check("t6_dcdone", 64'(dc_done), 64'd0);
    check("t6_icrdata", ic_rdata, exp_ic);
    check("t6_dcrdata", dc_rdata, exp_dc);
    tick();
    check("t6_busy2", 64'(busy), 64'd0);

    // 4: dcache read timeout
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 14'h0077;
    tick();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mem_re) break;
      cnt++;
      tick();
    end
    check("t4_re_cycles", 64'(cnt), 64'd255);
    check("t4_dcdone", 64'(dc_done), 64'd1);
    check("t4_err", 64'(err), 64'd1);
    check("t4_dcrdata_keep", dc_rdata, exp_dc);
    dc_req = 1'b0;
    tick();
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_dcdone_off", 64'(dc_done), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: reset during a write-back
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 14'h0111;
    dc_wdata = 64'hABCD_ABCD_ABCD_ABCD;
    tick();
    check("t5_we_before", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_we_drop", 64'(mem_we), 64'd0);
    check("t5_busy_drop", 64'(busy), 64'd0);
    check("t5_dcdone_drop", 64'(dc_done), 64'd0);
    check("t5_err_clear", 64'(err), 64'd0);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_err_after", 64'(err), 64'd0);
    check("t5_we_after", 64'(mem_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
